// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, next-PC select encoding, fault flag indices.
package cpu_pkg;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {PC_INC, PC_JMP, PC_CALL, PC_RET} pc_sel_t;

  localparam int FLT_OVF = 0;
  localparam int FLT_UDF = 1;
  localparam int FLT_ERR = 2;
  localparam int FLT_N   = 3;
endpackage

// File: rtl/pc_stack_if.sv
// Control-unit <-> PC/return-stack bundle: control requests in, PC and stack status out.
interface pc_stack_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic              s_inc;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tos;
  logic [DW-1:0]     depth;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              udf;
  logic              err;

  modport master (
    output s_inc, push, pop, target,
    input  pc, tos, depth, empty, full, ovf, udf, err
  );

  modport slave (
    input  s_inc, push, pop, target,
    output pc, tos, depth, empty, full, ovf, udf, err
  );
endinterface

// File: rtl/pc_stack_ret_lifo.sv
// Return-address LIFO: write at depth, combinational read of depth-1, occupancy counter.
module ret_lifo #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_data,
  output logic [ADDR_W-1:0] tos,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty
);
  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [AW-1:0]                wr_idx;
  logic [AW-1:0]                rd_idx;

  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  assign wr_idx = AW'(depth);
  assign rd_idx = AW'(depth - DW'(1));
  // Stale entries above depth are hidden by masking tos when empty.
  assign tos    = empty ? '0 : mem[rd_idx];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               depth <= '0;
    else if (wr_en && !full)    depth <= depth + DW'(1);
    else if (rd_en && !empty)   depth <= depth - DW'(1);
  end
endmodule

// File: rtl/pc_stack.sv
// Program counter with priority next-PC mux, hardware return stack and sticky fault flags.
module pc_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  pc_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_inc, pc_nxt, tos;
  logic [DW-1:0]     depth;
  logic              full, empty, wr_en, rd_en;
  logic [FLT_N-1:0]  flt_q, flt_set;
  pc_sel_t           sel;

  assign pc_inc = pc_q + ADDR_W'(1);

  // Conflict beats push beats pop beats s_inc; faulted requests fall back to pc+1.
  always_comb begin
    sel     = PC_INC;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flt_set = '0;
    if (bus.push && bus.pop) begin
      flt_set[FLT_ERR] = 1'b1;
    end else if (bus.push) begin
      if (!full) begin
        sel   = PC_CALL;
        wr_en = 1'b1;
      end else flt_set[FLT_OVF] = 1'b1;
    end else if (bus.pop) begin
      if (!empty) begin
        sel   = PC_RET;
        rd_en = 1'b1;
      end else flt_set[FLT_UDF] = 1'b1;
    end else if (!bus.s_inc) begin
      sel = PC_JMP;
    end
  end

  always_comb begin
    case (sel)
      PC_JMP, PC_CALL: pc_nxt = bus.target;
      PC_RET:          pc_nxt = tos;
      default:         pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      flt_q <= '0;
    end else begin
      pc_q  <= pc_nxt;
      flt_q <= flt_q | flt_set;
    end
  end

  ret_lifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (pc_inc),
    .tos     (tos),
    .depth   (depth),
    .full    (full),
    .empty   (empty)
  );

  assign bus.pc    = pc_q;
  assign bus.tos   = tos;
  assign bus.depth = depth;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = flt_q[FLT_OVF];
  assign bus.udf   = flt_q[FLT_UDF];
  assign bus.err   = flt_q[FLT_ERR];
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: sequencing, jumps, call/return, overflow/underflow, wrap, conflict, async reset.
module tb_pc_stack;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  pc_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [ADDR_W-1:0] a);
    bus.s_inc = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.target = a;
    step();
    bus.s_inc = 1'b1;
  endtask

  // status vector = {empty, full, ovf, udf, err}
  task automatic test_reset();
    bus.s_inc = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.target = '0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.pc, bus.depth, bus.tos} !== {10'h000, 4'd0, 10'h000}) begin
      errors++; $display("FAIL reset_pc_depth_tos: got %h/%0d/%h want 000/0/000", bus.pc, bus.depth, bus.tos);
    end
    checks++;
    if ({bus.empty, bus.full, bus.ovf, bus.udf, bus.err} !== 5'b10000) begin
      errors++; $display("FAIL reset_status: got %b want 10000", {bus.empty, bus.full, bus.ovf, bus.udf, bus.err});
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_seq();
    checks++;
    if (bus.pc !== 10'h000) begin
      errors++; $display("FAIL seq_pc0: got %h want 000", bus.pc);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (bus.pc !== ADDR_W'(i)) begin
        errors++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, ADDR_W'(i));
      end
    end
    checks++;
    if ({bus.depth, bus.empty, bus.full, bus.ovf, bus.udf, bus.err} !== {4'd0, 5'b10000}) begin
      errors++; $display("FAIL seq_status: got %0d/%b want 0/10000", bus.depth, {bus.empty, bus.full, bus.ovf, bus.udf, bus.err});
    end
  endtask

  task automatic test_jump();
    jump_to(10'h120);
    checks++;
    if ({bus.pc, bus.depth} !== {10'h120, 4'd0}) begin
      errors++; $display("FAIL jump: got %h/%0d want 120/0", bus.pc, bus.depth);
    end
  endtask

  task automatic test_call_ret();
    jump_to(10'h010);
    bus.push = 1'b1; bus.target = 10'h200;
    step();
    bus.push = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.tos, bus.empty} !== {10'h200, 4'd1, 10'h011, 1'b0}) begin
      errors++; $display("FAIL call: got pc=%h d=%0d tos=%h e=%b want 200/1/011/0", bus.pc, bus.depth, bus.tos, bus.empty);
    end
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.tos, bus.empty} !== {10'h011, 4'd0, 10'h000, 1'b1}) begin
      errors++; $display("FAIL ret: got pc=%h d=%0d tos=%h e=%b want 011/0/000/1", bus.pc, bus.depth, bus.tos, bus.empty);
    end
  endtask

  task automatic test_overflow();
    // Push i at pc P_i jumps to 0x080+0x20*i; return addresses are P_i+1.
    logic [ADDR_W-1:0] saved [DEPTH];
    logic [ADDR_W-1:0] exp_pc;
    jump_to(10'h100);
    exp_pc = 10'h100;
    for (int i = 0; i < DEPTH; i++) begin
      saved[i] = exp_pc + 10'd1;
      exp_pc   = 10'h080 + ADDR_W'(i * 32);
      bus.push = 1'b1; bus.target = exp_pc;
      step();
      checks++;
      if ({bus.pc, bus.depth, bus.tos} !== {exp_pc, 4'(i + 1), saved[i]}) begin
        errors++; $display("FAIL push%0d: got pc=%h d=%0d tos=%h want %h/%0d/%h", i, bus.pc, bus.depth, bus.tos, exp_pc, i + 1, saved[i]);
      end
    end
    checks++;
    if ({bus.full, bus.ovf} !== 2'b10) begin
      errors++; $display("FAIL full_after_8: got full/ovf=%b want 10", {bus.full, bus.ovf});
    end
    bus.target = 10'h3C0;
    step();
    bus.push = 1'b0;
    exp_pc = exp_pc + 10'd1;
    checks++;
    if ({bus.pc, bus.depth, bus.full, bus.ovf, bus.tos} !== {exp_pc, 4'd8, 2'b11, saved[DEPTH-1]}) begin
      errors++; $display("FAIL push_ovf: got pc=%h d=%0d full/ovf=%b tos=%h want %h/8/11/%h", bus.pc, bus.depth, {bus.full, bus.ovf}, bus.tos, exp_pc, saved[DEPTH-1]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      bus.pop = 1'b1;
      step();
      checks++;
      if ({bus.pc, bus.depth} !== {saved[i], 4'(i)}) begin
        errors++; $display("FAIL pop%0d: got pc=%h d=%0d want %h/%0d", i, bus.pc, bus.depth, saved[i], i);
      end
    end
    exp_pc = saved[0] + 10'd1;
    step();
    bus.pop = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.empty, bus.udf, bus.err} !== {exp_pc, 4'd0, 3'b110}) begin
      errors++; $display("FAIL pop_udf: got pc=%h d=%0d e/udf/err=%b want %h/0/110", bus.pc, bus.depth, {bus.empty, bus.udf, bus.err}, exp_pc);
    end
  endtask

  task automatic test_wrap();
    jump_to(10'h3FF);
    step();
    checks++;
    if (bus.pc !== 10'h000) begin
      errors++; $display("FAIL pc_wrap: got %h want 000", bus.pc);
    end
    jump_to(10'h3FF);
    bus.push = 1'b1; bus.target = 10'h050;
    step();
    bus.push = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.tos} !== {10'h050, 4'd1, 10'h000}) begin
      errors++; $display("FAIL ret_wrap: got pc=%h d=%0d tos=%h want 050/1/000", bus.pc, bus.depth, bus.tos);
    end
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    checks++;
    if ({bus.pc, bus.depth} !== {10'h000, 4'd0}) begin
      errors++; $display("FAIL ret_wrap_pop: got pc=%h d=%0d want 000/0", bus.pc, bus.depth);
    end
  endtask

  task automatic test_conflict_reset();
    jump_to(10'h040);
    bus.push = 1'b1; bus.pop = 1'b1; bus.target = 10'h2AA;
    step();
    bus.push = 1'b0; bus.pop = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.err} !== {10'h041, 4'd0, 1'b1}) begin
      errors++; $display("FAIL conflict: got pc=%h d=%0d err=%b want 041/0/1", bus.pc, bus.depth, bus.err);
    end
    for (int i = 0; i < 3; i++) begin
      bus.push = 1'b1; bus.target = 10'h300 + ADDR_W'(i);
      step();
    end
    bus.push = 1'b0;
    checks++;
    if ({bus.pc, bus.depth, bus.tos} !== {10'h302, 4'd3, 10'h302}) begin
      errors++; $display("FAIL pre_reset: got pc=%h d=%0d tos=%h want 302/3/302", bus.pc, bus.depth, bus.tos);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.pc, bus.depth, bus.tos, bus.empty, bus.full, bus.ovf, bus.udf, bus.err} !== {10'h000, 4'd0, 10'h000, 5'b10000}) begin
      errors++; $display("FAIL async_reset: got pc=%h d=%0d tos=%h st=%b want 000/0/000/10000", bus.pc, bus.depth, bus.tos, {bus.empty, bus.full, bus.ovf, bus.udf, bus.err});
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_jump();
    test_call_ret();
    test_overflow();
    test_wrap();
    test_conflict_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
